cushion_collision_ctrl: RTL and testbench



---
 rtl/cushion_collision_ctrl.sv | 152 +++++++++++++++
 tb/tb_cushion_collision_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cushion_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cushion_collision_ctrl
// Description : Per-frame cushion bounce resolver. It sits directly upstream
//               of the ball motion block and works in three steps:
//               - Collects per-pixel cushion overlap flags over a frame.
//               - At frame start, checks the overlap against the current ball
//                 velocity and computes damped reflected velocities.
//               - Issues them with a one-cycle write strobe, then ignores
//                 COOLDOWN_FRAMES frames so that a ball still overlapping the
//                 cushion does not bounce twice.
// Ports       : clk                  system clock
//               resetN               asynchronous active-low reset
//               startOfFrame         one-cycle frame strobe
//               collisionLeft/Right/Top/Bottom
//                                    ball pixel overlaps that cushion
//               ballVelocityX/Y      current signed velocity (11 bit)
//               velocityWriteEnable  one-cycle load strobe to motion block
//               outVelocityX/Y       velocity to load (11 bit signed)
//               bounceCount          total bounces issued, wraps at 255
// Revision    : 1.0 - initial release
// ============================================================================
module cushion_collision_ctrl #(
    parameter int RESTITUTION_NUM = 14,
    parameter int MIN_SPEED       = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collisionLeft,
    input  logic               collisionRight,
    input  logic               collisionTop,
    input  logic               collisionBottom,
    input  logic signed [10:0] ballVelocityX,
    input  logic signed [10:0] ballVelocityY,
    output logic               velocityWriteEnable,
    output logic signed [10:0] outVelocityX,
    output logic signed [10:0] outVelocityY,
    output logic [7:0]         bounceCount
);

    localparam int C_CW = $clog2(COOLDOWN_FRAMES + 2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_WRITE    = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [3:0]      r_acc;       // {left, right, top, bottom}
    logic [3:0]      w_acc_next;
    logic [3:0]      r_snap;
    logic [C_CW-1:0] r_cnt;
    logic [3:0]      w_flags;
    logic            w_qual_x;
    logic            w_qual_y;

    assign w_flags = {collisionLeft, collisionRight, collisionTop, collisionBottom};

    // An axis only bounces when the ball is moving into the flagged cushion;
    // with both opposite sides flagged the velocity sign picks the side.
    assign w_qual_x = (r_snap[3] & ballVelocityX[10]) |
                      (r_snap[2] & ~ballVelocityX[10] & (|ballVelocityX));
    assign w_qual_y = (r_snap[1] & ballVelocityY[10]) |
                      (r_snap[0] & ~ballVelocityY[10] & (|ballVelocityY));

    // Damped reflection. The magnitude is taken as unsigned so that -1024
    // becomes 1024 rather than overflowing.
    function automatic logic signed [10:0] reflect(input logic signed [10:0] v);
        logic [10:0] a;
        logic [14:0] p;
        logic [10:0] m;
        a = v[10] ? (11'd0 - $unsigned(v)) : $unsigned(v);
        p = 15'(a) * 15'(RESTITUTION_NUM);
        m = 11'(p >> 4);
        if (m > 11'd1023)
            m = 11'd1023;
        if (m < 11'(MIN_SPEED))
            m = 11'd0;
        return v[10] ? $signed(m) : $signed(11'd0 - m);
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state        = r_state;
        w_acc_next          = r_acc | w_flags;
        velocityWriteEnable = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (startOfFrame) begin
                    w_next_state = S_EVAL;
                    w_acc_next   = 4'd0;
                end
            end
            S_EVAL: begin
                w_next_state = (w_qual_x | w_qual_y) ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                velocityWriteEnable = 1'b1;
                w_next_state = (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                // Overlaps seen while cooling down belong to the bounce already
                // issued, so they are discarded.
                w_acc_next = 4'd0;
                if (startOfFrame && r_cnt == C_CW'(1))
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_acc        <= 4'd0;
            r_snap       <= 4'd0;
            r_cnt        <= '0;
            outVelocityX <= 11'sd0;
            outVelocityY <= 11'sd0;
            bounceCount  <= 8'd0;
        end else begin
            r_acc <= w_acc_next;
            // A collision on the strobe cycle itself belongs to the closing frame.
            if (r_state == S_IDLE && startOfFrame)
                r_snap <= r_acc | w_flags;
            // Velocity is sampled one cycle after the strobe so the motion
            // block's frame update is already reflected in it.
            if (r_state == S_EVAL && (w_qual_x | w_qual_y)) begin
                outVelocityX <= w_qual_x ? reflect(ballVelocityX) : ballVelocityX;
                outVelocityY <= w_qual_y ? reflect(ballVelocityY) : ballVelocityY;
            end
            if (r_state == S_WRITE) begin
                bounceCount <= bounceCount + 8'd1;
                r_cnt       <= C_CW'(COOLDOWN_FRAMES);
            end
            if (r_state == S_COOLDOWN && startOfFrame)
                r_cnt <= r_cnt - C_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cushion_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cushion_collision_ctrl
// Description : Self-checking bench for cushion_collision_ctrl. Directed
//               vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cushion_collision_ctrl;

    logic               clk = 1'b0;
    logic               resetN;
    logic               sof;
    logic               cl, cr, ct, cb;
    logic signed [10:0] vx, vy;
    logic               we, we16;
    logic signed [10:0] ox, oy, ox16, oy16;
    logic [7:0]         bc, bc16;

    int checks = 0;
    int errors = 0;

    cushion_collision_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .collisionLeft(cl), .collisionRight(cr), .collisionTop(ct), .collisionBottom(cb),
        .ballVelocityX(vx), .ballVelocityY(vy),
        .velocityWriteEnable(we), .outVelocityX(ox), .outVelocityY(oy), .bounceCount(bc)
    );

    cushion_collision_ctrl #(.RESTITUTION_NUM(16)) dut16 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .collisionLeft(cl), .collisionRight(cr), .collisionTop(ct), .collisionBottom(cb),
        .ballVelocityX(vx), .ballVelocityY(vy),
        .velocityWriteEnable(we16), .outVelocityX(ox16), .outVelocityY(oy16), .bounceCount(bc16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vx, vy;
        bit l, r, t, b;
        bit on_sof;
        bit exp_we;
        int exp_ox, exp_oy;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        sof = 1'b0;
        {cl, cr, ct, cb} = 4'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic pulse_left();
        cl = 1'b1;
        tick();
        cl = 1'b0;
        tick();
    endtask

    // Strobe startOfFrame, then check the write strobe on each of n cycles;
    // when expected it must appear exactly on the second cycle after the strobe.
    task automatic sof_watch(input string nm, input bit exp, input int n);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) tick();
            chk(nm, int'(we), (exp && i == 2) ? 1 : 0);
        end
    endtask

    vec_t vecs[11];

    initial begin
        resetN = 1'b0;
        sof = 1'b0;
        {cl, cr, ct, cb} = 4'b0;
        vx = '0;
        vy = '0;

        //          vx    vy   l r t b sof we  ox    oy
        vecs[0]  = '{-160,   32, 1,0,0,0, 0, 1,  140,   32};
        vecs[1]  = '{ 160,   32, 1,0,0,0, 0, 0,    0,    0};
        vecs[2]  = '{  64,   64, 0,1,0,1, 0, 1,  -56,  -56};
        vecs[3]  = '{  -4,   10, 1,0,0,0, 0, 1,    0,   10};
        vecs[4]  = '{  10,  -20, 0,0,1,0, 0, 1,   10,   17};
        vecs[5]  = '{  80,    5, 1,1,0,0, 0, 1,  -70,    5};
        vecs[6]  = '{   0,    7, 1,0,0,0, 0, 0,    0,    0};
        vecs[7]  = '{-1024,   0, 1,0,0,0, 0, 1,  896,    0};
        vecs[8]  = '{1023,    0, 0,1,0,0, 0, 1, -895,    0};
        vecs[9]  = '{   3,   -5, 0,0,1,0, 0, 1,    3,    4};
        vecs[10] = '{-160,    0, 1,0,0,0, 1, 1,  140,    0};

        do_reset();
        chk("reset_we", int'(we), 0);
        chk("reset_ox", int'(ox), 0);
        chk("reset_oy", int'(oy), 0);
        chk("reset_bc", int'(bc), 0);

        foreach (vecs[k]) begin
            do_reset();
            vx = 11'(vecs[k].vx);
            vy = 11'(vecs[k].vy);
            tick();
            if (!vecs[k].on_sof) begin
                {cl, cr, ct, cb} = {vecs[k].l, vecs[k].r, vecs[k].t, vecs[k].b};
                tick();
                {cl, cr, ct, cb} = 4'b0;
                tick();
                tick();
            end else begin
                {cl, cr, ct, cb} = {vecs[k].l, vecs[k].r, vecs[k].t, vecs[k].b};
            end
            sof = 1'b1;
            tick();
            sof = 1'b0;
            {cl, cr, ct, cb} = 4'b0;
            chk($sformatf("v%0d_eval_we", k), int'(we), 0);
            tick();
            chk($sformatf("v%0d_we", k), int'(we), int'(vecs[k].exp_we));
            chk($sformatf("v%0d_ox", k), int'(ox), vecs[k].exp_ox);
            chk($sformatf("v%0d_oy", k), int'(oy), vecs[k].exp_oy);
            tick();
            chk($sformatf("v%0d_after_we", k), int'(we), 0);
            chk($sformatf("v%0d_bc", k), int'(bc), vecs[k].exp_we ? 1 : 0);
        end

        // Full-scale restitution: 1024 saturates to 1023.
        do_reset();
        vx = -11'sd1024;
        vy = 11'sd0;
        pulse_left();
        sof_watch("sat_we", 1'b1, 3);
        chk("sat_ox16", int'(ox16), 1023);
        chk("sat_ox14", int'(ox), 896);

        // Cooldown: left held every frame, two frames skipped after a bounce.
        do_reset();
        vx = -11'sd100;
        vy = 11'sd0;
        cl = 1'b1;
        repeat (3) tick();
        sof_watch("cd_first", 1'b1, 6);
        chk("cd_first_ox", int'(ox), 87);
        chk("cd_first_bc", int'(bc), 1);
        repeat (3) tick();
        sof_watch("cd_skip1", 1'b0, 6);
        repeat (3) tick();
        sof_watch("cd_skip2", 1'b0, 6);
        repeat (3) tick();
        sof_watch("cd_third", 1'b1, 6);
        chk("cd_third_ox", int'(ox), 87);
        chk("cd_third_bc", int'(bc), 2);
        cl = 1'b0;

        // Flags arriving in EVAL roll into the next frame.
        do_reset();
        vx = -11'sd160;
        vy = 11'sd32;
        tick();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        cl = 1'b1;
        tick();
        cl = 1'b0;
        chk("late_no_we", int'(we), 0);
        repeat (3) tick();
        sof_watch("late_next", 1'b1, 3);
        chk("late_ox", int'(ox), 140);

        // Asynchronous reset while the strobe is high.
        do_reset();
        vx = -11'sd160;
        vy = 11'sd32;
        pulse_left();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
        chk("rw_pre_we", int'(we), 1);
        resetN = 1'b0;
        #1;
        chk("rw_we", int'(we), 0);
        chk("rw_bc", int'(bc), 0);
        chk("rw_ox", int'(ox), 0);
        tick();
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_quiet", int'(we), 0);
        end
        pulse_left();
        sof_watch("rw_next", 1'b1, 3);
        chk("rw_next_bc", int'(bc), 1);
        chk("rw_next_ox", int'(ox), 140);

        // Asynchronous reset while cooling down: next flagged frame bounces.
        tick();
        resetN = 1'b0;
        #1;
        chk("rc_bc", int'(bc), 0);
        chk("rc_ox", int'(ox), 0);
        tick();
        resetN = 1'b1;
        tick();
        pulse_left();
        sof_watch("rc_next", 1'b1, 3);
        chk("rc_next_bc", int'(bc), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
